// File: rtl/pipelined_shifter_pkg.sv
// shifter_pkg: shared op encoding, control payload and shift-level distribution helpers.
package shifter_pkg;
  typedef enum logic [2:0] {SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4} shift_op_t;
  typedef struct packed {
    shift_op_t op;
    logic      word;
  } shift_ctl_t;
  function automatic int lg2(input int w);
    return $clog2(w);
  endfunction
  // Levels go high-first; the earliest stages absorb any remainder.
  function automatic int lvl_cnt(input int l, input int st, input int s);
    return l / st + ((s < l % st) ? 1 : 0);
  endfunction
  function automatic int lvl_hi(input int l, input int st, input int s);
    return l - 1 - s * (l / st) - ((s < l % st) ? s : l % st);
  endfunction
endpackage

// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: op request / result handshake bundle for the pipelined shifter.
interface pipelined_shifter_if #(parameter int DATA_WIDTH = 32, parameter int TAG_WIDTH = 5);
  logic                  valid_i, ready_o, word_i, flush_i, valid_o, ready_i;
  logic [DATA_WIDTH-1:0] data_i, amount_i, data_o;
  logic [2:0]            op_i;
  logic [TAG_WIDTH-1:0]  tag_i, tag_o;
  modport slave (input valid_i, data_i, amount_i, op_i, word_i, tag_i, flush_i, ready_i,
                 output ready_o, valid_o, data_o, tag_o);
  modport master (output valid_i, data_i, amount_i, op_i, word_i, tag_i, flush_i, ready_i,
                  input ready_o, valid_o, data_o, tag_o);
endinterface

// File: rtl/pipelined_shifter_level_stage.sv
// shift_level_stage: combinational slice applying shift levels LEVEL_LO..LEVEL_HI for every op.
module shift_level_stage
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL_LO   = 0,
  parameter int LEVEL_HI   = 0
) (
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic [LEVEL_HI-LEVEL_LO:0] amt_i,
  input  shift_op_t                  op_i,
  input  logic                       word_i,
  output logic [DATA_WIDTH-1:0]      data_o
);
  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] x, input shift_op_t op,
                                                 input int n, input logic w);
    logic [31:0]           l, wa, wr;
    logic [DATA_WIDTH-1:0] fa, f;
    l  = x[31:0];
    fa = $signed(x) >>> n;
    wa = $signed(l) >>> n;
    f  = op == SLL ? x << n : op == SRL ? x >> n : op == SRA ? fa :
         op == ROL ? (x << n) | (x >> (DATA_WIDTH - n)) :
         op == ROR ? (x >> n) | (x << (DATA_WIDTH - n)) : '0;
    wr = op == SLL ? l << n : op == SRL ? l >> n : op == SRA ? wa :
         op == ROL ? (l << n) | (l >> (32 - n)) :
         op == ROR ? (l >> n) | (l << (32 - n)) : '0;
    return w ? DATA_WIDTH'(wr) : f;
  endfunction
  always_comb begin
    data_o = data_i;
    for (int k = LEVEL_LO; k <= LEVEL_HI; k++)
      if (amt_i[k-LEVEL_LO]) data_o = step(data_o, op_i, 1 << k, word_i);
  end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: valid/ready pipelined shift/rotate unit with RV64 word forms and flush.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 5
) (
  input logic                clk,
  input logic                reset_n,
  pipelined_shifter_if.slave s
);
  localparam int LW = lg2(DATA_WIDTH);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [LW-1:0]         amt;
    shift_ctl_t            ctl;
    logic [TAG_WIDTH-1:0]  tag;
  } pay_t;
  pay_t              pay_q [STAGES];
  pay_t              pay_d [STAGES];
  logic [STAGES-1:0] vld_q, vld_d, in_v;
  logic [STAGES:0]   go;
  logic              word_m;
  assign word_m = DATA_WIDTH == 64 && s.word_i;
  assign in_v   = STAGES'({vld_q, s.valid_i});
  always_comb begin
    go[STAGES] = s.ready_i;
    for (int i = STAGES - 1; i >= 0; i--) go[i] = !vld_q[i] || go[i+1];
  end
  assign vld_d     = s.flush_i ? '0 : (go[STAGES-1:0] & in_v) | (~go[STAGES-1:0] & vld_q);
  assign s.ready_o = go[0] && !s.flush_i;
  assign s.valid_o = vld_q[STAGES-1];
  assign s.data_o  = pay_q[STAGES-1].data;
  assign s.tag_o   = pay_q[STAGES-1].tag;
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    localparam int HI = lvl_hi(LW, STAGES, g);
    localparam int LO = HI - lvl_cnt(LW, STAGES, g) + 1;
    pay_t                  cur;
    logic [DATA_WIDTH-1:0] sh;
    if (g == 0) begin : g_in
      // Word ops enter as a zero-extended 32-bit operand with a 5-bit amount.
      assign cur = '{data: word_m ? DATA_WIDTH'(s.data_i[31:0]) : s.data_i,
                     amt:  s.amount_i[LW-1:0] & ~(word_m ? LW'(32) : LW'(0)),
                     ctl:  '{op: shift_op_t'(s.op_i), word: word_m},
                     tag:  s.tag_i};
    end else begin : g_mid
      assign cur = pay_q[g-1];
    end
    shift_level_stage #(.DATA_WIDTH(DATA_WIDTH), .LEVEL_LO(LO), .LEVEL_HI(HI)) u_lvl (
      .data_i(cur.data), .amt_i(cur.amt[HI:LO]), .op_i(cur.ctl.op), .word_i(cur.ctl.word), .data_o(sh)
    );
    if (g == STAGES - 1) begin : g_fin
      logic signed [31:0]           lo32;
      logic signed [DATA_WIDTH-1:0] sx;
      always_comb begin
        lo32       = sh[31:0];
        sx         = lo32;
        pay_d[g]      = cur;
        pay_d[g].data = cur.ctl.op > ROR ? '0 : cur.ctl.word ? sx : sh;
      end
    end else begin : g_pass
      always_comb begin
        pay_d[g]      = cur;
        pay_d[g].data = sh;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) pay_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) if (go[i] && in_v[i]) pay_q[i] <= pay_d[i];
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed and reference-model checks of pipelined_shifter at 32/64 bits.
module tb_pipelined_shifter;
  logic clk = 1'b0, reset_n = 1'b0;
  int   n_vec = 0, n_err = 0;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) a();
  pipelined_shifter_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) b();
  pipelined_shifter #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(5)) u_a (.clk(clk), .reset_n(reset_n), .s(a.slave));
  pipelined_shifter #(.DATA_WIDTH(64), .STAGES(3), .TAG_WIDTH(5)) u_b (.clk(clk), .reset_n(reset_n), .s(b.slave));

  logic        sw_v;
  logic [31:0] sw_d, sw_amt;
  logic [2:0]  sw_op;
  logic [4:0]  sw_tag;
  logic [4:0]  sv_vo;
  logic [31:0] sv_do [5];
  logic [4:0]  sv_to [5];
  for (genvar g = 0; g < 5; g++) begin : g_sw
    pipelined_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) w();
    assign w.valid_i  = sw_v;
    assign w.data_i   = sw_d;
    assign w.amount_i = sw_amt;
    assign w.op_i     = sw_op;
    assign w.word_i   = 1'b0;
    assign w.tag_i    = sw_tag;
    assign w.flush_i  = 1'b0;
    assign w.ready_i  = 1'b1;
    pipelined_shifter #(.DATA_WIDTH(32), .STAGES(g + 1), .TAG_WIDTH(5)) u (.clk(clk), .reset_n(reset_n), .s(w.slave));
    assign sv_vo[g] = w.valid_o;
    assign sv_do[g] = w.data_o;
    assign sv_to[g] = w.tag_o;
  end

  function automatic logic [63:0] ref_sh(input int dw, input logic [63:0] x, input logic [2:0] op,
                                         input logic [63:0] amount, input logic word);
    int          n;
    logic        w;
    logic [31:0] l, r32;
    logic [63:0] r64;
    w = word && dw == 64;
    n = (w || dw == 32) ? int'(amount[4:0]) : int'(amount[5:0]);
    l = x[31:0];
    if (w || dw == 32) begin
      case (op)
        3'd0: r32 = l << n;
        3'd1: r32 = l >> n;
        3'd2: r32 = $signed(l) >>> n;
        3'd3: r32 = (l << n) | (l >> (32 - n));
        3'd4: r32 = (l >> n) | (l << (32 - n));
        default: r32 = 32'd0;
      endcase
      return w ? {{32{r32[31]}}, r32} : {32'd0, r32};
    end
    case (op)
      3'd0: r64 = x << n;
      3'd1: r64 = x >> n;
      3'd2: r64 = $signed(x) >>> n;
      3'd3: r64 = (x << n) | (x >> (64 - n));
      3'd4: r64 = (x >> n) | (x << (64 - n));
      default: r64 = 64'd0;
    endcase
    return r64;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op_a(input string nm, input logic [31:0] d, input logic [31:0] amt, input logic [2:0] op,
                      input logic [4:0] tag, input logic [31:0] exp);
    @(negedge clk);
    a.valid_i = 1'b1; a.data_i = d; a.amount_i = amt; a.op_i = op; a.tag_i = tag;
    #1 chk({nm, "_rdy"}, 64'(a.ready_o), 64'd1);
    @(negedge clk);
    a.valid_i = 1'b0;
    chk({nm, "_lat1"}, 64'(a.valid_o), 64'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 64'(a.valid_o), 64'd1);
    chk({nm, "_data"}, 64'(a.data_o), 64'(exp));
    chk({nm, "_tag"}, 64'(a.tag_o), 64'(tag));
  endtask

  task automatic op_b(input string nm, input logic [63:0] d, input logic [63:0] amt, input logic [2:0] op,
                      input logic wd, input logic [4:0] tag, input logic [63:0] exp);
    @(negedge clk);
    b.valid_i = 1'b1; b.data_i = d; b.amount_i = amt; b.op_i = op; b.word_i = wd; b.tag_i = tag;
    #1 chk({nm, "_rdy"}, 64'(b.ready_o), 64'd1);
    @(negedge clk);
    b.valid_i = 1'b0;
    chk({nm, "_lat1"}, 64'(b.valid_o), 64'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 64'(b.valid_o), 64'd0);
    @(negedge clk);
    chk({nm, "_lat3"}, 64'(b.valid_o), 64'd1);
    chk({nm, "_data"}, b.data_o, exp);
    chk({nm, "_tag"}, 64'(b.tag_o), 64'(tag));
  endtask

  function automatic logic [31:0] bp_d(input int t);
    return 32'(t) * 32'h0101_0101;
  endfunction

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: bench did not reach its summary");
  end

  initial begin
    logic [63:0] e, d, amt;
    logic [31:0] held;
    logic [2:0]  op;
    logic        wd, stalled, saw_full;
    int          sent, got;
    a.valid_i = 0; a.data_i = 0; a.amount_i = 0; a.op_i = 0; a.word_i = 0; a.tag_i = 0; a.flush_i = 0; a.ready_i = 1;
    b.valid_i = 0; b.data_i = 0; b.amount_i = 0; b.op_i = 0; b.word_i = 0; b.tag_i = 0; b.flush_i = 0; b.ready_i = 1;
    sw_v = 0; sw_d = 0; sw_amt = 0; sw_op = 0; sw_tag = 0;
    #1;
    chk("rst_valid_o", 64'(a.valid_o), 64'd0);
    chk("rst_data_o", 64'(a.data_o), 64'd0);
    chk("rst_tag_o", 64'(a.tag_o), 64'd0);
    chk("rst_ready_o", 64'(a.ready_o), 64'd1);
    chk("rst_b_valid_o", 64'(b.valid_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    op_a("sll4", 32'h0000_00F1, 32'd4, 3'd0, 5'd1, 32'h0000_0F10);
    op_a("sra31", 32'h8000_0000, 32'd31, 3'd2, 5'd2, 32'hFFFF_FFFF);
    op_a("ror1", 32'h0000_0001, 32'd1, 3'd4, 5'd3, 32'h8000_0000);
    op_a("srl_mask", 32'hF000_0000, 32'h0000_0024, 3'd1, 5'd4, 32'h0F00_0000);
    op_a("rsvd6", 32'h1234_5678, 32'd3, 3'd6, 5'd5, 32'h0000_0000);
    op_a("rol_amt0", 32'hDEAD_BEEF, 32'h0000_0020, 3'd3, 5'd6, 32'hDEAD_BEEF);
    op_a("rol5", 32'hF000_000F, 32'd5, 3'd3, 5'd7, 32'h0000_01FE);

    op_b("w_sll", 64'h0000_0000_4000_0000, 64'd1, 3'd0, 1'b1, 5'd8, 64'hFFFF_FFFF_8000_0000);
    op_b("w_sra", 64'h1234_5678_8000_0000, 64'd4, 3'd2, 1'b1, 5'd9, 64'hFFFF_FFFF_F800_0000);
    op_b("w_rol", 64'h0000_0000_8000_0001, 64'd1, 3'd3, 1'b1, 5'd10, 64'h0000_0000_0000_0003);
    op_b("d_ror", 64'h0000_0000_0000_0001, 64'd1, 3'd4, 1'b0, 5'd11, 64'h8000_0000_0000_0000);
    op_b("w_srl_mask", 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_0021, 3'd1, 1'b1, 5'd12, 64'h0000_0000_4000_0000);

    sent = 0; got = 0; stalled = 0; saw_full = 0; held = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      a.ready_i = !(c >= 3 && c < 6);
      a.valid_i = sent < 6;
      a.data_i = bp_d(sent + 1); a.amount_i = 32'(sent + 1); a.op_i = 3'((sent + 1) % 5); a.tag_i = 5'(sent + 1);
      #1;
      if (!a.ready_o) saw_full = 1;
      if (a.valid_o && !a.ready_i) begin
        if (stalled) chk("bp_hold", 64'(a.data_o), 64'(held));
        held = a.data_o;
        stalled = 1;
      end else stalled = 0;
      if (a.valid_o && a.ready_i) begin
        chk("bp_tag", 64'(a.tag_o), 64'(got + 1));
        chk("bp_data", 64'(a.data_o), ref_sh(32, 64'(bp_d(got + 1)), 3'((got + 1) % 5), 64'(got + 1), 1'b0));
        got++;
      end
      if (a.valid_i && a.ready_o) sent++;
    end
    a.valid_i = 0; a.ready_i = 1;
    chk("bp_got", 64'(got), 64'd6);
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_ready_drop", 64'(saw_full), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_no_dup", 64'(a.valid_o), 64'd0);
    end

    @(negedge clk);
    b.valid_i = 1; b.word_i = 0; b.data_i = 64'h1; b.amount_i = 64'd1; b.op_i = 3'd0; b.tag_i = 5'd20;
    @(negedge clk);
    b.tag_i = 5'd21;
    @(negedge clk);
    b.tag_i = 5'd22; b.flush_i = 1;
    #1 chk("fl_ready_o", 64'(b.ready_o), 64'd0);
    @(negedge clk);
    b.flush_i = 0; b.valid_i = 0;
    for (int c = 0; c < 5; c++) begin
      chk("fl_none", 64'(b.valid_o), 64'd0);
      @(negedge clk);
    end
    op_b("fl_after", 64'h0000_0000_0000_00FF, 64'd8, 3'd0, 1'b0, 5'd23, 64'h0000_0000_0000_FF00);

    for (int v = 0; v < 20; v++) begin
      d = {$urandom, $urandom}; amt = 64'($urandom); op = 3'($urandom_range(0, 7)); wd = 1'($urandom_range(0, 1));
      op_b("rnd64", d, amt, op, wd, 5'(v), ref_sh(64, d, op, amt, wd));
    end

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      sw_v = 1; sw_d = $urandom; sw_amt = $urandom; sw_op = 3'($urandom_range(0, 7)); sw_tag = 5'(v);
      e = ref_sh(32, 64'(sw_d), sw_op, 64'(sw_amt), 1'b0);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        sw_v = 0;
        chk("sweep_valid", 64'(sv_vo[c-1]), 64'd1);
        chk("sweep_data", 64'(sv_do[c-1]), e);
        chk("sweep_tag", 64'(sv_to[c-1]), 64'(v));
      end
    end

    @(negedge clk);
    a.ready_i = 0; a.valid_i = 1; a.data_i = 32'h5; a.amount_i = 32'd1; a.op_i = 3'd0; a.tag_i = 5'd24;
    @(negedge clk);
    a.tag_i = 5'd25;
    @(negedge clk);
    a.valid_i = 0;
    chk("rs_pre_valid", 64'(a.valid_o), 64'd1);
    #2 reset_n = 0;
    #1;
    chk("rs_valid_o", 64'(a.valid_o), 64'd0);
    chk("rs_data_o", 64'(a.data_o), 64'd0);
    chk("rs_tag_o", 64'(a.tag_o), 64'd0);
    @(negedge clk);
    reset_n = 1; a.ready_i = 1;
    @(negedge clk);
    chk("rs_after_valid", 64'(a.valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
